reg_readback: RTL and testbench

- Reader counterpart to the team's enabled 8-bit register write path.
- On a start request, snapshots a bank of NUM_REGS registers presented as a flat bus.
- Streams the snapshot out one register per beat over a valid/ready interface, lowest index first.
- Used for debug and state dump: a register bank feeds the block, and a UART or trace sink consumes the stream.

---
 rtl/reg_readback.sv | 127 ++++++++++++
 tb/tb_reg_readback.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_readback.sv
// Snapshot a flat register bank on start_i, then stream it out one register per beat, lowest index first.
// First beat appears the cycle after the start edge. While ready_i is low, the current beat stays stable. done_o pulses one cycle after the last beat is accepted.
module reg_readback #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int IDX_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic [NUM_REGS*DATA_W-1:0] regs_i,
  input  logic                       ready_i,
  output logic [DATA_W-1:0]          d_out,
  output logic [IDX_W-1:0]           idx_o,
  output logic                       valid_o,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  snap_q [NUM_REGS];
  logic [DATA_W-1:0]  snap_d [NUM_REGS];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   idx_nxt;
  logic [DATA_W-1:0]  d_out_q, d_out_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    d_out_d = d_out_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            snap_d[k] = regs_i[k*DATA_W +: DATA_W];
          end
          d_out_d = regs_i[0 +: DATA_W];
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          // The last-index compare stops the counter, so unused codes are never reached.
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_nxt;
            d_out_d = snap_q[idx_nxt];
            last_d  = (idx_nxt == LAST_IDX);
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int k = 0; k < NUM_REGS; k++) begin
        snap_q[k] <= '0;
      end
      idx_q   <= '0;
      d_out_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      d_out_q <= d_out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign d_out   = d_out_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_reg_readback.sv
// Self-checking bench for reg_readback: expected beats are queued at each start and compared as the sink accepts them.
module tb_reg_readback;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int IW = 3;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_i;
  logic [N*DW-1:0] regs_i;
  logic            ready_i;
  logic [DW-1:0]   d_out;
  logic [IW-1:0]   idx_o;
  logic            valid_o, last_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  reg_readback #(.NUM_REGS(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .regs_i(regs_i), .ready_i(ready_i),
    .d_out(d_out), .idx_o(idx_o), .valid_o(valid_o), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] descending();
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(N - 1 - k);
    return v;
  endfunction

  task automatic push_stream(input logic [N*DW-1:0] bank);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.idx  = IW'(k);
      b.data = bank[k*DW +: DW];
      b.last = (k == N - 1);
      exp_q.push_back(b);
    end
  endtask

  // Called at a negedge where the first beat is visible; stall_mode 1 drops ready every other cycle.
  task automatic consume(input int stall_mode, input int max_beats, output int accepted);
    int cyc;
    beat_t exp;
    accepted = 0;
    cyc = 0;
    while (exp_q.size() > 0 && accepted < max_beats) begin
      exp = exp_q[0];
      checks++;
      if ({valid_o, busy_o, done_o, idx_o, d_out, last_o} !== {3'b110, exp}) begin
        errors++;
        $display("FAIL beat got v=%0b b=%0b d=%0b idx=%0d data=%02h last=%0b need v=1 b=1 d=0 idx=%0d data=%02h last=%0b",
                 valid_o, busy_o, done_o, idx_o, d_out, last_o, exp.idx, exp.data, exp.last);
      end
      ready_i = (stall_mode == 1) ? cyc[0] : 1'b1;
      if (ready_i) begin
        void'(exp_q.pop_front());
        accepted++;
      end
      cyc++;
      if (cyc > 100) begin
        errors++;
        $display("FAIL consume_timeout got %0d beats need %0d", accepted, max_beats);
        exp_q.delete();
      end
      @(negedge clk);
    end
  endtask

  task automatic check_done();
    checks++;
    if ({valid_o, last_o, busy_o, done_o} !== 4'b0011) begin
      errors++;
      $display("FAIL done_pulse got v/l/b/d=%04b need 0011", {valid_o, last_o, busy_o, done_o});
    end
    @(negedge clk);
    checks++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL after_done got v/b/d=%03b need 000", {valid_o, busy_o, done_o});
    end
  endtask

  task automatic start_stream(input logic [N*DW-1:0] bank);
    regs_i  = bank;
    start_i = 1'b1;
    push_stream(bank);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start_i = 1'b0; ready_i = 1'b0; regs_i = '1;
    repeat (2) @(negedge clk);
    checks++;
    if ({d_out, idx_o, valid_o, last_o, busy_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h need 0", {d_out, idx_o, valid_o, last_o, busy_o, done_o});
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ready_i = $urandom_range(0, 1);
      @(negedge clk);
      checks++;
      if ({d_out, idx_o, valid_o, last_o, busy_o, done_o} !== '0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d got %h need 0", i, {d_out, idx_o, valid_o, last_o, busy_o, done_o});
      end
    end
  endtask

  task automatic test_stream(input int stall_mode);
    int acc;
    start_stream(descending());
    consume(stall_mode, N, acc);
    checks++;
    if (acc != N) begin
      errors++;
      $display("FAIL beat_count got %0d need %0d", acc, N);
    end
    check_done();
  endtask

  task automatic test_snapshot();
    int acc;
    logic [N*DW-1:0] bank;
    for (int k = 0; k < N; k++) bank[k*DW +: DW] = DW'($urandom_range(0, 254));
    start_stream(bank);
    regs_i = '1;
    consume(1, N, acc);
    check_done();
  endtask

  task automatic test_back_to_back();
    int acc;
    logic [N*DW-1:0] bank_b;
    regs_i  = descending();
    start_i = 1'b1;
    push_stream(regs_i);
    @(negedge clk);
    consume(0, N, acc);
    checks++;
    if ({valid_o, busy_o, done_o} !== 3'b011) begin
      errors++;
      $display("FAIL b2b_done got v/b/d=%03b need 011", {valid_o, busy_o, done_o});
    end
    for (int k = 0; k < N; k++) bank_b[k*DW +: DW] = DW'(8'h50 + k);
    regs_i = bank_b;
    @(negedge clk);
    checks++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle_gap got v/b/d=%03b need 000", {valid_o, busy_o, done_o});
    end
    push_stream(bank_b);
    @(negedge clk);
    start_i = 1'b0;
    consume(0, N, acc);
    check_done();
    @(negedge clk);
    checks++;
    if ({valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_no_extra got v/b=%02b need 00", {valid_o, busy_o});
    end
  endtask

  task automatic test_reset_mid_stream();
    int acc;
    int seen_done;
    start_stream(descending());
    consume(0, 3, acc);
    reset = 1'b0;
    #1;
    checks++;
    if ({d_out, idx_o, valid_o, last_o, busy_o, done_o} !== '0) begin
      errors++;
      $display("FAIL midreset_clear got %h need 0", {d_out, idx_o, valid_o, last_o, busy_o, done_o});
    end
    exp_q.delete();
    seen_done = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done_o || valid_o) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL midreset_quiet got %0d active cycles need 0", seen_done);
    end
    test_stream(0);
  endtask

  initial begin
    test_reset();
    test_stream(0);
    test_stream(1);
    test_snapshot();
    test_back_to_back();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got hang need finish");
    $fatal(1);
  end
endmodule
